// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
// Bridges the core's data port onto a variable-latency req/ack memory bus.
// Stores are posted into a one-entry write buffer so the core does not wait
// on write latency. Reads stall the core until the slave acknowledges. Every
// bus transaction is guarded by a timeout so a dead slave cannot hang the
// pipeline.
//
// Ports:
//   clock, reset             sole clock; synchronous active-high reset
//   cpu_addr/cpu_ren/cpu_wen core request (held while cpu_ready=0)
//   cpu_wdata/cpu_be         lane-aligned store data and byte enables
//   cpu_rdata                read data, valid in the read-completion cycle
//   cpu_ready                memReady to the core (combinational)
//   mem_req/mem_we           bus request / direction (registered)
//   mem_addr/mem_be          word-aligned address and byte enables (registered)
//   mem_wdata                bus write data (registered)
//   mem_ack/mem_rdata        one-cycle completion strobe and read data
//   wbuf_busy                write buffer holds an undrained store
//   bus_error/err_addr       sticky timeout flag and address of last timeout
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wbuf_busy,
  output logic        bus_error,
  output logic [31:0] err_addr
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              mem_req_r, mem_req_s;
  logic              mem_we_r, mem_we_s;
  logic [31:0]       mem_addr_r, mem_addr_s;
  logic [3:0]        mem_be_r, mem_be_s;
  logic [31:0]       mem_wdata_r, mem_wdata_s;
  logic [31:0]       cpu_rdata_r, cpu_rdata_s;
  logic              wbuf_busy_r, wbuf_busy_s;
  logic              bus_error_r, bus_error_s;
  logic [31:0]       err_addr_r, err_addr_s;
  logic [CNT_W-1:0]  tmo_cnt_r, tmo_cnt_s;
  logic              cpu_ready_s;
  logic              timeout_s;

  // Byte offset is dropped on the bus; the byte enables select the lanes.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^cpu_addr[1:0];

  // Abort when the last allowed busy cycle passes without an ack.
  assign timeout_s = (tmo_cnt_r == CNT_LAST) && !mem_ack;

  // Next-state, next-register values and the combinational ready.
  always_comb begin
    state_s     = state_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_be_s    = mem_be_r;
    mem_wdata_s = mem_wdata_r;
    cpu_rdata_s = cpu_rdata_r;
    wbuf_busy_s = wbuf_busy_r;
    bus_error_s = bus_error_r;
    err_addr_s  = err_addr_r;
    tmo_cnt_s   = tmo_cnt_r;
    cpu_ready_s = 1'b0;

    case (state_r)
      IDLE: begin
        // A posted write is accepted immediately; a read always stalls.
        cpu_ready_s = !cpu_ren;
        if (cpu_ren) begin
          // Read wins when both are requested; the write is dropped.
          state_s    = RD_BUSY;
          mem_req_s  = 1'b1;
          mem_we_s   = 1'b0;
          mem_addr_s = {cpu_addr[31:2], 2'b00};
          mem_be_s   = cpu_be;
          tmo_cnt_s  = CNT_ZERO;
        end else if (cpu_wen) begin
          state_s     = WR_BUSY;
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b1;
          mem_addr_s  = {cpu_addr[31:2], 2'b00};
          mem_be_s    = cpu_be;
          mem_wdata_s = cpu_wdata;
          wbuf_busy_s = 1'b1;
          tmo_cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end

      WR_BUSY: begin
        // Hold off any request so nothing overtakes the buffered store.
        cpu_ready_s = !(cpu_ren || cpu_wen);
        if (mem_ack) begin
          state_s     = IDLE;
          mem_req_s   = 1'b0;
          wbuf_busy_s = 1'b0;
        end else if (timeout_s) begin
          state_s     = IDLE;
          mem_req_s   = 1'b0;
          wbuf_busy_s = 1'b0;
          bus_error_s = 1'b1;
          err_addr_s  = mem_addr_r;
        end else begin
          tmo_cnt_s = tmo_cnt_r + CNT_ONE;
        end
      end

      RD_BUSY: begin
        cpu_ready_s = !(cpu_ren || cpu_wen);
        if (mem_ack) begin
          state_s     = RD_DONE;
          mem_req_s   = 1'b0;
          cpu_rdata_s = mem_rdata;
        end else if (timeout_s) begin
          state_s     = RD_DONE;
          mem_req_s   = 1'b0;
          cpu_rdata_s = ERR_RDATA;
          bus_error_s = 1'b1;
          err_addr_s  = mem_addr_r;
        end else begin
          tmo_cnt_s = tmo_cnt_r + CNT_ONE;
        end
      end

      RD_DONE: begin
        // Completion cycle; a request next cycle is a new transaction.
        cpu_ready_s = 1'b1;
        state_s     = IDLE;
      end

      default: begin
        state_s     = IDLE;
        mem_req_s   = 1'b0;
        wbuf_busy_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any bus transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      cpu_rdata_r <= 32'h0000_0000;
      wbuf_busy_r <= 1'b0;
      bus_error_r <= 1'b0;
      err_addr_r  <= 32'h0000_0000;
      tmo_cnt_r   <= CNT_ZERO;
    end else begin
      state_r     <= state_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_be_r    <= mem_be_s;
      mem_wdata_r <= mem_wdata_s;
      cpu_rdata_r <= cpu_rdata_s;
      wbuf_busy_r <= wbuf_busy_s;
      bus_error_r <= bus_error_s;
      err_addr_r  <= err_addr_s;
      tmo_cnt_r   <= tmo_cnt_s;
    end
  end

  // Ready is forced low while reset is held.
  assign cpu_ready = cpu_ready_s && !reset;
  assign cpu_rdata = cpu_rdata_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;
  assign wbuf_busy = wbuf_busy_r;
  assign bus_error = bus_error_r;
  assign err_addr  = err_addr_r;

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

- Data-memory bridge directly downstream of the CPU's data port.
- CPU side: the core's `ren`/`wen`/`data_addr`/`data_out`/`byte_select` are converted into a req/ack transaction on a variable-latency memory bus. Read data returns on `data_in` and the core is stalled through `memReady`.
- Stores are posted into a one-entry write buffer so the core does not wait on write latency.
- A per-transaction timeout counter keeps a dead slave from hanging the pipeline.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles `mem_req` stays high without `mem_ack` before the transaction is aborted (≥2).
- ERR_RDATA, 32'h0000_0000: read data returned on an aborted read.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  32  byte address from the core.
- cpu_ren  in  1  read request; held by the core while `cpu_ready`=0.
- cpu_wen  in  1  write request; held by the core while `cpu_ready`=0.
- cpu_wdata  in  32  lane-aligned store data.
- cpu_be  in  4  byte enables.
- cpu_rdata  out  32  read data; valid only in a read-completion cycle.
- cpu_ready  out  1  memReady to the core; 0 means the core holds its request.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned address: {cpu_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_ack  in  1  one-cycle completion strobe from the slave; read data valid in the same cycle.
- mem_rdata  in  32  read data from the slave.
- wbuf_busy  out  1  write buffer holds an undrained store.
- bus_error  out  1  sticky; set on any timeout, cleared only by reset.
- err_addr  out  32  mem_addr of the most recent timed-out transaction.

## Operation
- FSM states: IDLE, WR_BUSY, RD_BUSY, RD_DONE.
- IDLE:
  - `cpu_ren`=1: latch addr/be, go to RD_BUSY, `cpu_ready`=0.
  - `cpu_wen`=1 (and `cpu_ren`=0): latch addr/be/wdata into the write buffer, go to WR_BUSY, `cpu_ready`=1 in the same cycle (posted write).
  - No request: `cpu_ready`=1.
  - Both `cpu_ren` and `cpu_wen` high: the read is performed and the write is dropped.
- WR_BUSY:
  - `mem_req`=1, `mem_we`=1, fields driven from the buffer.
  - On `mem_ack`: clear the buffer, go to IDLE.
  - Any CPU request in this state sees `cpu_ready`=0. This enforces ordering: no read overtakes a buffered write, and there is no second buffered write.
- RD_BUSY:
  - `mem_req`=1, `mem_we`=0.
  - On `mem_ack`: register `mem_rdata` into `cpu_rdata`, go to RD_DONE.
- RD_DONE:
  - `cpu_ready`=1, `cpu_rdata` valid; go unconditionally to IDLE.
  - A request present in the following cycle is treated as new.
- All bus outputs are registered. mem_addr/mem_be/mem_wdata/mem_we stay stable for the entire time `mem_req`=1.
- Timeout:
  - Counter clears on entry to WR_BUSY/RD_BUSY and increments every busy cycle without `mem_ack`.
  - If the count equals TIMEOUT_CYCLES-1 and `mem_ack`=0, the transaction is aborted at that edge: `mem_req` drops, `bus_error`<=1, `err_addr`<=mem_addr.
  - Aborted read: goes to RD_DONE with `cpu_rdata`=ERR_RDATA.
  - Aborted write: buffer discarded, go to IDLE.
  - `mem_ack` in the final allowed cycle counts as success.
- `mem_ack` received while `mem_req`=0 is ignored.

## Timing
- Reset values, held while `reset`=1:
  - state IDLE.
  - `mem_req`=0, `mem_we`=0, mem_addr/mem_be/mem_wdata=0.
  - `cpu_rdata`=0, `cpu_ready`=0.
  - `wbuf_busy`=0, `bus_error`=0, `err_addr`=0.
- Reset mid-transaction abandons the request; `mem_req` is low after the reset edge.
- Read, request seen at cycle 0: `mem_req` high from cycle 1; `mem_ack` at cycle k≥1; RD_DONE and `cpu_ready`=1 at k+1. A zero-wait slave gives 3 cycles total, ready at cycle 2.
- Write: accepted at cycle 0 with `cpu_ready`=1; `mem_req` from cycle 1 to the ack cycle k; `wbuf_busy`=1 for cycles 1..k; IDLE at k+1.
- `cpu_ready` is combinational from state and cpu_ren/cpu_wen. Every other output is registered.
- Timeout: `mem_req` is high for exactly TIMEOUT_CYCLES cycles, then low; `bus_error` rises on the cycle after the last `mem_req` cycle.

## Test plan
- Reset then idle: all outputs 0 during reset; after reset with no request, `cpu_ready`=1 and `mem_req`=0.
- Read at addr 0x1006, be 4'b0100, slave acks at cycle 1 with 0xCAFEBABE: `mem_addr`=0x1004; `cpu_ready` is 0,0,1 over cycles 0–2; `cpu_rdata`=0xCAFEBABE at cycle 2.
- Write to 0x2000 with 0x12345678 and a 3-cycle slave, followed by a read the cycle after: write accepted with ready=1; the read stalls until `wbuf_busy` falls; the read's `mem_req` asserts only after the write ack.
- Back-to-back writes: the second write sees `cpu_ready`=0 until the first ack, then is accepted in IDLE.
- Read with a slave that never acks, TIMEOUT_CYCLES=4: `mem_req` high exactly 4 cycles; `cpu_rdata`=ERR_RDATA with ready=1; `bus_error`=1 and `err_addr`=request address. A subsequent read to a responsive slave completes normally with `bus_error` still 1.
- `reset` asserted while in RD_BUSY: `mem_req`=0 and state IDLE after the edge; a late `mem_ack` is ignored.
